// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The stage itself connects through the slave modport; the environment uses master.

interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_ra;
    logic [2:0]  out_rb;
    logic [2:0]  out_rc;
    logic [8:0]  out_imm9;
    logic [15:0] out_imm_sext;
    logic        out_is_lui;
    logic [15:0] out_pc;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_ra, out_rb, out_rc,
               out_imm9, out_imm_sext, out_is_lui, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_ra, out_rb, out_rc,
               out_imm9, out_imm_sext, out_is_lui, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Fetch-to-execute pipeline register with field decode and a 2-entry skid buffer.
// Optional illegal-opcode trap enabled by defining DECODE_ILLEGAL_TRAP_EN.

module decode_stage #(
    parameter logic [3:0] LUI_OPCODE    = 4'h3,
    parameter int         NUM_LEGAL_OPS = 12
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rc;
        logic [8:0]  imm9;
        logic [15:0] imm_sext;
        logic        is_lui;
        logic [15:0] pc;
        logic        illegal;
    } entry_t;

    // An opcode field can never exceed 15, so 16 or more legal ops means none trap.
    if (NUM_LEGAL_OPS < 1 || NUM_LEGAL_OPS > 16) begin : g_num_legal_ops_out_of_range
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic [4:0] NUM_LEGAL = 5'(NUM_LEGAL_OPS);
`endif

    function automatic entry_t decode(input logic [15:0] instr, input logic [15:0] pc);
        entry_t e;
        e.opcode   = instr[15:12];
        e.ra       = instr[11:9];
        e.rb       = instr[8:6];
        e.rc       = instr[5:3];
        e.imm9     = instr[8:0];
        e.imm_sext = {{10{instr[5]}}, instr[5:0]};
        e.is_lui   = (instr[15:12] == LUI_OPCODE);
        e.pc       = pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.illegal  = ({1'b0, instr[15:12]} >= NUM_LEGAL);
        // Trapped words execute as NOP; operand fields stay for trap reporting.
        if (e.illegal) begin
            e.opcode = 4'h0;
            e.is_lui = 1'b0;
        end
`else
        e.illegal  = 1'b0;
`endif
        return e;
    endfunction

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;

    entry_t in_dec;
    logic   in_xfer;
    logic   out_xfer;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
        end
    end

    // NOTE: the skid entry is only read while state is TWO, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    // Next-state and entry-write logic; decode happens here so outputs come from flops.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_dec   = decode(bus.in_instr, bus.in_pc);
        in_xfer  = bus.in_valid && in_ready_q;
        out_xfer = (state_q != EMPTY) && bus.out_ready;

        if (bus.flush) begin
            // An output transfer this cycle still completes; any offered input is dropped.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_d  = in_dec;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_dec;
                    end else if (in_xfer) begin
                        state_d = TWO;
                        skid_d  = in_dec;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        in_ready_d = (state_d != TWO);
    end

    // Outputs.
    always_comb begin
        bus.in_ready     = in_ready_q;
        bus.out_valid    = (state_q != EMPTY);
        bus.out_opcode   = main_q.opcode;
        bus.out_ra       = main_q.ra;
        bus.out_rb       = main_q.rb;
        bus.out_rc       = main_q.rc;
        bus.out_imm9     = main_q.imm9;
        bus.out_imm_sext = main_q.imm_sext;
        bus.out_is_lui   = main_q.is_lui;
        bus.out_pc       = main_q.pc;
        bus.out_illegal  = main_q.illegal;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then a randomized phase.

module tb_decode_stage;

    logic clk;
    logic rst;

    decode_stage_if bus ();

    decode_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of held words with capacity two.
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } item_t;

    item_t mq[$];
    bit    m_ready     = 1'b0;
    bit    m_live      = 1'b0;
    bit    m_was_reset = 1'b0;

    task automatic model_step();
        item_t it;
        bit in_x;
        bit out_x;
        m_live = 1'b1;
        if (rst) begin
            mq.delete();
            m_ready     = 1'b0;
            m_was_reset = 1'b1;
        end else begin
            m_was_reset = 1'b0;
            in_x  = bus.in_valid && m_ready;
            out_x = bus.out_ready && (mq.size() != 0);
            if (out_x) void'(mq.pop_front());
            if (bus.flush) begin
                mq.delete();
            end else if (in_x) begin
                it.instr = bus.in_instr;
                it.pc    = bus.in_pc;
                mq.push_back(it);
            end
            m_ready = (mq.size() < 2);
        end
    endtask

    task automatic compare();
        item_t it;
        int op, ra, rb, rc, imm9, low6;
        logic [15:0] sx;
        bit lui, ill;
        check("in_ready", bus.in_ready, m_ready);
        check("out_valid", bus.out_valid, mq.size() != 0);
        if (m_was_reset) begin
            check("rst_opcode", bus.out_opcode, 0);
            check("rst_regs", {bus.out_ra, bus.out_rb, bus.out_rc}, 0);
            check("rst_imm9", bus.out_imm9, 0);
            check("rst_imm_sext", bus.out_imm_sext, 0);
            check("rst_is_lui", bus.out_is_lui, 0);
            check("rst_pc", bus.out_pc, 0);
            check("rst_illegal", bus.out_illegal, 0);
        end else if (mq.size() != 0) begin
            it   = mq[0];
            op   = int'(it.instr) / 4096;
            ra   = (int'(it.instr) / 512) % 8;
            rb   = (int'(it.instr) / 64) % 8;
            rc   = (int'(it.instr) / 8) % 8;
            imm9 = int'(it.instr) % 512;
            low6 = int'(it.instr) % 64;
            sx   = (low6 < 32) ? 16'(low6) : 16'(65472 + low6);
            lui  = (op == 3);
            ill  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (op >= 12) begin
                ill = 1'b1;
                op  = 0;
                lui = 1'b0;
            end
`endif
            check("out_opcode", bus.out_opcode, 64'(op));
            check("out_ra", bus.out_ra, 64'(ra));
            check("out_rb", bus.out_rb, 64'(rb));
            check("out_rc", bus.out_rc, 64'(rc));
            check("out_imm9", bus.out_imm9, 64'(imm9));
            check("out_imm_sext", bus.out_imm_sext, sx);
            check("out_is_lui", bus.out_is_lui, lui);
            check("out_pc", bus.out_pc, it.pc);
            check("out_illegal", bus.out_illegal, ill);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) compare();
    end

    task automatic drive(input bit v, input logic [15:0] w, input logic [15:0] pc);
        bus.in_valid = v;
        bus.in_instr = w;
        bus.in_pc    = pc;
    endtask

    int n_out;
    int n_rdy;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset and LUI decode.
        repeat (2) @(negedge clk);
        check("lit_rst_in_ready", bus.in_ready, 0);
        check("lit_rst_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("lit_post_rst_in_ready", bus.in_ready, 1);
        drive(1'b1, 16'h31FF, 16'h0010);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("lit_lui_valid", bus.out_valid, 1);
        check("lit_lui_is_lui", bus.out_is_lui, 1);
        check("lit_lui_ra", bus.out_ra, 0);
        check("lit_lui_imm9", bus.out_imm9, 9'h1FF);
        check("lit_lui_pc", bus.out_pc, 16'h0010);

        // Field slicing and sign extension.
        drive(1'b1, 16'h1A5F, 16'h0012);
        @(negedge clk);
        check("lit_1a5f_opcode", bus.out_opcode, 1);
        check("lit_1a5f_ra", bus.out_ra, 5);
        check("lit_1a5f_rb", bus.out_rb, 1);
        check("lit_1a5f_rc", bus.out_rc, 3);
        check("lit_1a5f_sext", bus.out_imm_sext, 16'h001F);
        drive(1'b1, 16'h1020, 16'h0014);
        @(negedge clk);
        check("lit_1020_sext", bus.out_imm_sext, 16'hFFE0);
        check("lit_1020_is_lui", bus.out_is_lui, 0);
        drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("lit_drained", bus.out_valid, 0);

        // Backpressure fills the skid, then A, B, C drain in order.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h2111, 16'h0100);
        @(negedge clk);
        drive(1'b1, 16'h4222, 16'h0102);
        @(negedge clk);
        drive(1'b1, 16'h5333, 16'h0104);
        @(negedge clk);
        check("lit_bp_valid", bus.out_valid, 1);
        check("lit_bp_pc_a", bus.out_pc, 16'h0100);
        check("lit_bp_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("lit_bp_pc_b", bus.out_pc, 16'h0102);
        @(negedge clk);
        check("lit_bp_pc_c", bus.out_pc, 16'h0104);
        drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("lit_bp_drained", bus.out_valid, 0);

        // Flush while full, with a word offered on the flush cycle.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h7444, 16'h0200);
        @(negedge clk);
        drive(1'b1, 16'h8555, 16'h0202);
        @(negedge clk);
        drive(1'b1, 16'h9666, 16'h0204);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("lit_flush2_valid", bus.out_valid, 0);
        check("lit_flush2_in_ready", bus.in_ready, 1);
        drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("lit_flush2_stays_empty", bus.out_valid, 0);

        // Flush with one held and an output transfer on the same cycle.
        drive(1'b1, 16'hA777, 16'h0210);
        @(negedge clk);
        drive(1'b1, 16'hB888, 16'h0212);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        check("lit_flush1_valid", bus.out_valid, 0);
        @(negedge clk);

        // Illegal opcode.
        drive(1'b1, 16'hE123, 16'h0300);
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("lit_ill_flag", bus.out_illegal, 1);
        check("lit_ill_opcode", bus.out_opcode, 0);
`else
        check("lit_ill_flag", bus.out_illegal, 0);
        check("lit_ill_opcode", bus.out_opcode, 4'hE);
`endif
        check("lit_ill_rb", bus.out_rb, 4);
        check("lit_ill_imm9", bus.out_imm9, 9'h123);
        check("lit_ill_pc", bus.out_pc, 16'h0300);
        @(negedge clk);

        // Throughput: 20 back-to-back words with execute always ready.
        n_out = 0;
        n_rdy = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 16'($urandom), 16'(16'h0400 + 2 * k));
            if (bus.in_ready) n_rdy++;
            @(negedge clk);
            if (bus.out_valid) n_out++;
        end
        drive(1'b0, 16'h0000, 16'h0000);
        check("lit_tput_outputs", n_out, 20);
        check("lit_tput_in_ready", n_rdy, 20);
        @(negedge clk);

        // Randomized traffic with occasional flush and reset.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline register and field decoder between instruction fetch and execute in the 16-bit core.
- Accepts one 16-bit instruction per cycle over a valid/ready handshake and splits it into opcode, register indices and immediates.
- Presents the 9-bit upper-immediate field to the upper-immediate shifter (imm9 << 7 → 16-bit) and a sign-extended 6-bit immediate to the ALU.
- Contains a 2-entry skid buffer, so fetch is never combinationally stalled by execute.

Parameters:
- LUI_OPCODE, 4'h3, opcode whose payload is the 9-bit upper immediate.
- NUM_LEGAL_OPS, 12, opcodes 0..NUM_LEGAL_OPS-1 are legal; the rest are illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  16  instruction word.
- in_pc  input  16  instruction address.
- flush  input  1  discard all held instructions (branch redirect).
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  execute accepts.
- out_opcode  output  4  instr[15:12].
- out_ra  output  3  instr[11:9].
- out_rb  output  3  instr[8:6].
- out_rc  output  3  instr[5:3].
- out_imm9  output  9  instr[8:0]; feeds the upper-immediate shifter.
- out_imm_sext  output  16  instr[5:0] sign-extended (bit 5 replicated into [15:6]).
- out_is_lui  output  1  out_opcode == LUI_OPCODE.
- out_pc  output  16  in_pc carried with the instruction.
- out_illegal  output  1  opcode >= NUM_LEGAL_OPS (see Optional Feature).

Behaviour:
- Clock and reset: a single clock, clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset values: all outputs 0, both entries empty, in_ready 0 while rst is high. in_ready is 1 on the first cycle after rst deasserts.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Storage: entry MAIN drives the outputs; entry SKID is a backup. State is encoded as EMPTY (0 held), ONE (MAIN only), TWO (MAIN + SKID).
- EMPTY:
  - input transfer → ONE; the decoded word appears on the outputs the next cycle (latency 1).
- ONE:
  - input and output transfer together → ONE, MAIN replaced.
  - input transfer only → TWO, new word into SKID.
  - output transfer only → EMPTY.
- TWO:
  - output transfer → ONE, SKID moves to MAIN.
  - no input accepted (in_ready = 0).
- in_ready is registered: 1 next cycle iff the next state is not TWO.
- Ordering: FIFO order is strict; no instruction is duplicated or dropped except by flush or rst.
- Decode timing: decode is performed on entry write and stored, so outputs are register-driven with no combinational path from in_instr.
- Field extraction is pure slicing. Fields are produced for every opcode regardless of format; execute selects which to use.
- flush:
  - Next state is EMPTY, out_valid 0 next cycle, in_ready 1 next cycle.
  - An input offered on the flush cycle is dropped.
  - An output transfer on the flush cycle still completes (execute already took it).
  - flush and rst together: rst wins, giving the same result.
- Data outputs while out_valid = 0 hold their last values and carry no meaning.
- out_valid must not deassert without an output transfer, flush or rst.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - out_illegal = 1 for opcode >= NUM_LEGAL_OPS.
  - That entry's out_opcode is forced to 4'h0 (NOP) and out_is_lui to 0.
  - All other fields and out_pc pass unchanged for trap reporting.
- Undefined:
  - out_illegal is tied 0.
  - Opcodes pass through raw.
  - No compare logic is synthesised.

Test Plan:
- Reset/LUI decode: rst high 2 cycles → in_ready 0, out_valid 0. Then in_instr 16'h31FF, pc 16'h0010, out_ready 1 → next cycle: out_valid 1, out_is_lui 1, out_ra 0, out_imm9 9'h1FF, out_pc 16'h0010.
- Field/sign-extension: 16'h1A5F → opcode 1, ra 5, rb 1, rc 3, imm_sext 16'h001F. 16'h1020 → imm_sext 16'hFFE0.
- Backpressure/skid: out_ready 0, stream A, B, C with in_valid held → A on outputs, B in SKID, in_ready 0, C held by fetch. Raise out_ready → A, B, C emerge in order on consecutive cycles, none lost or duplicated.
- Flush in state TWO with an input offered the same cycle → next cycle out_valid 0, in_ready 1. The offered word never appears on the outputs.
- Illegal opcode 16'hE123:
  - With DECODE_ILLEGAL_TRAP_EN: out_illegal 1, out_opcode 0.
  - Without: out_illegal 0, out_opcode 4'hE.
- Throughput: back-to-back valid inputs with out_ready 1 for 20 cycles → 20 outputs, one per cycle, in_ready constantly 1.
